// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Request/grant/rvalid bus between the load/store unit and data memory.
// Handshake: o_dmem_req stays high with we/addr/be/wdata stable until a cycle
// in which i_dmem_gnt is high; that cycle transfers the request. For loads,
// i_dmem_rvalid with i_dmem_rdata follows at least one cycle after the grant.
interface riscv_lsu_if #(
   parameter int XLEN = 32
);
   logic            o_dmem_req;
   logic            o_dmem_we;
   logic [XLEN-1:0] o_dmem_addr;
   logic [3:0]      o_dmem_be;
   logic [XLEN-1:0] o_dmem_wdata;
   logic            i_dmem_gnt;
   logic            i_dmem_rvalid;
   logic [XLEN-1:0] i_dmem_rdata;

   modport master (
      output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
      input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
   );

   modport slave (
      input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
      output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
   );
endinterface

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: aligns stores onto byte lanes, extends loads, and
// stalls the core across a multi-cycle request/grant/rvalid memory access.
module riscv_lsu #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_lsu_req,
   input  logic            i_lsu_we,
   input  logic [2:0]      i_lsu_funct3,
   input  logic [XLEN-1:0] i_lsu_addr,
   input  logic [XLEN-1:0] i_lsu_wdata,
   output logic [XLEN-1:0] o_lsu_rdata,
   output logic            o_lsu_done,
   output logic            o_lsu_stall,
   output logic            o_lsu_misalign,
   output logic [1:0]      o_dbg_state,
   riscv_lsu_if.master     dmem
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      off_q, off_d;
   logic [2:0]      f3_q, f3_d;
   logic            we_q, we_d;
   logic            req_q, req_d;
   logic            dwe_q, dwe_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [3:0]      be_q, be_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            done_q, done_d;
   logic            mis_q, mis_d;

   logic            in_byte, in_half, in_mis;
   logic [3:0]      in_be;
   logic [XLEN-1:0] in_wdata;
   logic [XLEN-1:0] shifted, load_ext;

   // Decode of the incoming instruction; funct3[1:0] other than 00/01 is a word.
   always_comb begin
      in_byte  = (i_lsu_funct3[1:0] == 2'b00);
      in_half  = (i_lsu_funct3[1:0] == 2'b01);
      in_mis   = (in_half && i_lsu_addr[0]) ||
                 (!in_byte && !in_half && (i_lsu_addr[1:0] != 2'b00));
      in_be    = 4'b1111;
      in_wdata = i_lsu_wdata;
      if (in_byte) begin
         in_be    = 4'b0001 << i_lsu_addr[1:0];
         in_wdata = {4{i_lsu_wdata[7:0]}};
      end else if (in_half) begin
         in_be    = 4'b0011 << i_lsu_addr[1:0];
         in_wdata = {2{i_lsu_wdata[15:0]}};
      end
   end

   always_comb begin
      shifted  = dmem.i_dmem_rdata >> {off_q, 3'b000};
      load_ext = shifted;
      case (f3_q[1:0])
         2'b00:   load_ext = f3_q[2] ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_ext = f3_q[2] ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = dmem.i_dmem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      f3_d    = f3_q;
      we_d    = we_q;
      req_d   = req_q;
      dwe_d   = dwe_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      mis_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_lsu_req) begin
               off_d = i_lsu_addr[1:0];
               f3_d  = i_lsu_funct3;
               we_d  = i_lsu_we;
               if (in_mis) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  mis_d   = 1'b1;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  dwe_d   = i_lsu_we;
                  addr_d  = {i_lsu_addr[XLEN-1:2], 2'b00};
                  be_d    = in_be;
                  wdata_d = in_wdata;
               end
            end
         end
         S_REQ: begin
            if (dmem.i_dmem_gnt) begin
               req_d   = 1'b0;
               dwe_d   = 1'b0;
               state_d = we_q ? S_DONE : S_WAIT;
               done_d  = we_q;
            end
         end
         S_WAIT: begin
            if (dmem.i_dmem_rvalid) begin
               rdata_d = load_ext;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         off_q   <= 2'd0;
         f3_q    <= 3'd0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
         dwe_q   <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'd0;
         wdata_q <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
         req_q   <= req_d;
         dwe_q   <= dwe_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
      end
   end

   assign o_lsu_rdata       = rdata_q;
   assign o_lsu_done        = done_q;
   assign o_lsu_misalign    = mis_q;
   assign o_lsu_stall       = i_lsu_req && !done_q;
   assign o_dbg_state       = state_q;
   assign dmem.o_dmem_req   = req_q;
   assign dmem.o_dmem_we    = dwe_q;
   assign dmem.o_dmem_addr  = addr_q;
   assign dmem.o_dmem_be    = be_q;
   assign dmem.o_dmem_wdata = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: byte-array reference model, randomized memory latency
// slave, and a monitor that pops expected completions and bus requests.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        lsu_req = 1'b0;
   logic        lsu_we = 1'b0;
   logic [2:0]  lsu_f3 = 3'd0;
   logic [31:0] lsu_addr = 32'd0;
   logic [31:0] lsu_wdata = 32'd0;
   logic [31:0] lsu_rdata;
   logic        lsu_done, lsu_stall, lsu_mis;
   logic [1:0]  dbg_state;

   riscv_lsu_if #(.XLEN(32)) dmem ();

   riscv_lsu #(.XLEN(32)) dut (
      .i_clk          (clk),
      .i_rstn         (rst_n),
      .i_lsu_req      (lsu_req),
      .i_lsu_we       (lsu_we),
      .i_lsu_funct3   (lsu_f3),
      .i_lsu_addr     (lsu_addr),
      .i_lsu_wdata    (lsu_wdata),
      .o_lsu_rdata    (lsu_rdata),
      .o_lsu_done     (lsu_done),
      .o_lsu_stall    (lsu_stall),
      .o_lsu_misalign (lsu_mis),
      .o_dbg_state    (dbg_state),
      .dmem           (dmem)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          gnt_dly = 0;
   int          rv_dly = 0;
   logic [32:0] exp_q[$];   // {misalign, rdata}
   logic [69:0] bus_q[$];   // {check_wdata, we, be, addr, wdata}
   logic [7:0]  ref_mem [0:1023];
   logic [31:0] slv_mem [0:255];
   logic [31:0] last_rdata = 32'd0;

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   // Reference model plus driver for one core instruction; n = cycles to done.
   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int n);
      int          sz, base, a0;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] wl, v;
      sz   = size_of(f3);
      base = int'(addr - 32'h100);
      a0   = int'(addr[1:0]);
      mis  = (a0 % sz) != 0;
      be   = 4'd0;
      wl   = 32'd0;
      v    = 32'd0;
      if (!mis) begin
         for (int i = 0; i < sz; i++) be[a0 + i] = 1'b1;
         for (int k = 0; k < 4; k++) wl[8*k +: 8] = wdata[8*(k % sz) +: 8];
         bus_q.push_back({we, we, be, addr & 32'hFFFF_FFFC, wl});
         if (we) begin
            for (int i = 0; i < sz; i++) ref_mem[base + i] = wdata[8*i +: 8];
         end else begin
            for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[base + i];
            if (!f3[2] && sz < 4 && v[8*sz-1])
               for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
            last_rdata = v;
         end
      end
      exp_q.push_back({mis, last_rdata});
      @(negedge clk);
      lsu_req = 1'b1; lsu_we = we; lsu_f3 = f3; lsu_addr = addr; lsu_wdata = wdata;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!lsu_done && n < 60);
      check("done_seen", lsu_done, 1'b1);
      lsu_req = 1'b0;
   endtask

   // Memory slave: grant after gnt_dly cycles of request, rvalid rv_dly cycles after.
   initial begin
      int g_cnt, rv_cnt, rv_idx, idx;
      logic rv_pend;
      g_cnt = 0; rv_cnt = 0; rv_idx = 0; rv_pend = 1'b0;
      dmem.i_dmem_gnt = 1'b0; dmem.i_dmem_rvalid = 1'b0; dmem.i_dmem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         dmem.i_dmem_gnt = 1'b0;
         dmem.i_dmem_rvalid = 1'b0;
         if (rv_pend) begin
            if (rv_cnt == 0) begin
               dmem.i_dmem_rvalid = 1'b1;
               dmem.i_dmem_rdata = slv_mem[rv_idx];
               rv_pend = 1'b0;
            end else rv_cnt--;
         end else if (dmem.o_dmem_req) begin
            if (g_cnt == 0) begin
               dmem.i_dmem_gnt = 1'b1;
               idx = int'((dmem.o_dmem_addr - 32'h100) >> 2) & 255;
               if (dmem.o_dmem_we) begin
                  for (int l = 0; l < 4; l++)
                     if (dmem.o_dmem_be[l]) slv_mem[idx][8*l +: 8] = dmem.o_dmem_wdata[8*l +: 8];
               end else begin
                  rv_pend = 1'b1; rv_cnt = rv_dly; rv_idx = idx;
               end
            end else g_cnt--;
         end else g_cnt = gnt_dly;
      end
   end

   // Monitor: completions against exp_q, bus requests against bus_q every cycle.
   initial begin
      logic [32:0] e;
      logic [69:0] b;
      forever begin
         @(negedge clk); #1;
         check("stall", lsu_stall, lsu_req && !lsu_done);
         if (lsu_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = exp_q.pop_front();
               check("misalign", lsu_mis, e[32]);
               check("rdata", lsu_rdata, e[31:0]);
            end
         end else check("misalign_no_done", lsu_mis, 1'b0);
         if (dmem.o_dmem_req) begin
            if (bus_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_req actual=1 required=0 addr=%0h", dmem.o_dmem_addr);
            end else begin
               b = bus_q[0];
               check("dmem_we", dmem.o_dmem_we, b[68]);
               check("dmem_be", dmem.o_dmem_be, b[67:64]);
               check("dmem_addr", dmem.o_dmem_addr, b[63:32]);
               if (b[69]) check("dmem_wdata", dmem.o_dmem_wdata, b[31:0]);
               if (dmem.i_dmem_gnt) void'(bus_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n, d0;
      logic [31:0] w;
      for (int i = 0; i < 256; i++) begin
         w = (i == 64) ? 32'h8001_7FFF : $urandom;
         slv_mem[i] = w;
         for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
      end
      #1 rst_n = 1'b0;
      #2;
      check("rst_rdata", lsu_rdata, 32'd0);
      check("rst_done", lsu_done, 1'b0);
      check("rst_req", dmem.o_dmem_req, 1'b0);
      check("rst_be", dmem.o_dmem_be, 4'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      do_op(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, n);
      check("sw_latency", n, 2);
      do_op(1'b1, 3'b000, 32'h103, 32'h0000_00A5, n);
      check("sb_latency", n, 2);
      rv_dly = 1;
      do_op(1'b0, 3'b000, 32'h103, 32'd0, n);
      check("lb_latency", n, 4);
      check("lb_value", lsu_rdata, 32'hFFFF_FFA5);
      do_op(1'b0, 3'b100, 32'h103, 32'd0, n);
      check("lbu_value", lsu_rdata, 32'h0000_00A5);
      rv_dly = 0;
      do_op(1'b0, 3'b001, 32'h202, 32'd0, n);
      check("lh_latency", n, 3);
      check("lh_value", lsu_rdata, 32'hFFFF_8001);
      do_op(1'b0, 3'b101, 32'h202, 32'd0, n);
      check("lhu_value", lsu_rdata, 32'h0000_8001);
      do_op(1'b0, 3'b010, 32'h106, 32'd0, n);
      check("lw_mis_latency", n, 1);
      do_op(1'b1, 3'b001, 32'h301, 32'h1234_5678, n);
      check("sh_mis_latency", n, 1);
      gnt_dly = 5;
      do_op(1'b1, 3'b010, 32'h180, $urandom, n);
      check("sw_gnt5_latency", n, 7);

      // Reset while a load waits for rvalid; the late rvalid must not complete anything.
      gnt_dly = 0; rv_dly = 10;
      bus_q.push_back({1'b0, 1'b0, 4'b1111, 32'h140, 32'd0});
      @(negedge clk);
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_f3 = 3'b010; lsu_addr = 32'h140;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (dbg_state != 2'd2 && n < 20);
      check("reach_wait", dbg_state, 2'd2);
      #2 rst_n = 1'b0;
      last_rdata = 32'd0;
      #1;
      check("arst_rdata", lsu_rdata, 32'd0);
      check("arst_done", lsu_done, 1'b0);
      check("arst_mis", lsu_mis, 1'b0);
      check("arst_req", dmem.o_dmem_req, 1'b0);
      check("arst_we", dmem.o_dmem_we, 1'b0);
      check("arst_addr", dmem.o_dmem_addr, 32'd0);
      check("arst_be", dmem.o_dmem_be, 4'd0);
      check("arst_wdata", dmem.o_dmem_wdata, 32'd0);
      d0 = done_cnt;
      @(negedge clk);
      lsu_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      #2;
      check("no_done_after_reset", done_cnt, d0);

      for (int t = 0; t < 200; t++) begin
         logic we;
         we = 1'($urandom_range(0, 1));
         gnt_dly = $urandom_range(0, 3);
         rv_dly  = $urandom_range(0, 3);
         do_op(we, we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7)),
               32'h100 + 32'($urandom_range(0, 1023)), $urandom, n);
      end

      repeat (3) @(negedge clk);
      #2;
      check("exp_q_drained", exp_q.size(), 0);
      check("bus_q_drained", bus_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
